pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline around the instruction decoder: load-use stalls, jr operand stalls, jump/branch flushes and interrupt entry/return.
- Sits beside the decoder. Consumes ID-stage PCSrc and register indices plus EX/MEM destination info. Drives PC/IF-ID write enables, stage flushes and the exception-entry controls.
- Keeps a saturating stall-cycle counter for debug readout.

Parameters:
REG_AW, 5, register index width
CNT_W, 32, stall counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
id_pcsrc  in  3  decoder PCSrc of ID instruction (0 seq, 1 branch, 2 j/jal, 3 jr)
id_rs  in  REG_AW  ID rs index
id_rt  in  REG_AW  ID rt index
id_uses_rt  in  1  ID instruction reads rt
ex_memrd  in  1  EX instruction is a load
ex_regwr  in  1  EX instruction writes a register
ex_rd  in  REG_AW  EX destination index
mem_memrd  in  1  MEM instruction is a load
mem_rd  in  REG_AW  MEM destination index
ex_br_taken  in  1  EX branch resolved taken
irq  in  1  level interrupt request
eret  in  1  one-cycle pulse: handler return executed in ID
pc_wr  out  1  PC write enable
ifid_wr  out  1  IF/ID write enable
ifid_flush  out  1  bubble IF/ID
idex_flush  out  1  bubble ID/EX
exc_pc_sel  out  1  PC ← handler vector this cycle
epc_wr  out  1  latch ID-stage PC into EPC
irq_ack  out  1  one-cycle interrupt acknowledge
in_handler  out  1  interrupt being serviced
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset=0 at posedge): FSM=IDLE, stall_cnt=0. Registered outputs irq_ack=0 and in_handler=0. Combinational outputs settle to defaults: pc_wr=1, ifid_wr=1, all flushes/exc_pc_sel/epc_wr=0. Reset mid-handler drops to IDLE immediately.
- Register 0 never causes a hazard. Any match against index 0 is ignored.
- load_use = ex_memrd & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- jr_haz = id_pcsrc==3 & id_rs≠0 & ((ex_regwr & ex_rd==id_rs) | (mem_memrd & mem_rd==id_rs)).
- stall = load_use | jr_haz. Stall drives pc_wr=0, ifid_wr=0, idex_flush=1. Re-evaluated every cycle, so an EX load feeding jr yields 2 stall cycles.
- ex_br_taken has top priority. It drives ifid_flush=1, idex_flush=1, pc_wr=1, ifid_wr=1, and suppresses stall.
- Jump (id_pcsrc 2 or 3) with no stall and no ex_br_taken: ifid_flush=1 (kill fetched slot).
- stall_cnt increments on each stall cycle, saturates at all-ones, never wraps.
- Interrupt FSM:
  - IDLE: irq=1 → PEND.
  - PEND: irq is latched, so dropping it does not cancel. Advance → TAKE in the first cycle with no stall, no ex_br_taken and id_pcsrc==0.
  - TAKE, 1 cycle: exc_pc_sel=1, epc_wr=1, pc_wr=1, ifid_flush=1, idex_flush=1. Registered irq_ack=1 next cycle. → HANDLER.
  - HANDLER: in_handler=1. irq ignored (no nesting). eret=1 → IDLE; in_handler clears next cycle.
  - eret outside HANDLER is ignored.
- Hazard logic keeps operating in HANDLER.
- Latency: hazard outputs are combinational (same cycle). FSM outputs follow state registers.

Decomposition:
- Shared package: PCSrc encodings (PCSRC_SEQ=0, PCSRC_BR=1, PCSRC_J=2, PCSRC_JR=3) and FSM state encodings IDLE/PEND/TAKE/HANDLER.
- One natural sub-module: irq_seq_fsm, holding the interrupt FSM and irq_ack/in_handler registers. Hazard detection and stall_cnt stay in the top.

Test Plan:
- ex_memrd=1, ex_rd=8, id_rs=8, id_pcsrc=0 → one cycle pc_wr=0, ifid_wr=0, idex_flush=1; stall_cnt 0→1.
- ex_memrd=1, ex_rd=9, id_rt=9, id_uses_rt=0 → no stall; ex_rd=0, id_rs=0 → no stall.
- id_pcsrc=3, id_rs=31, EX load rd=31 then MEM load rd=31 → two consecutive stalls, then ifid_flush=1 on the third cycle.
- ex_br_taken=1 together with load_use → ifid_flush=idex_flush=1, pc_wr=1, stall_cnt unchanged.
- irq pulse 1 cycle while id_pcsrc=2 → PEND held. Next cycle with id_pcsrc=0 gives TAKE: exc_pc_sel=epc_wr=1. irq_ack=1 one cycle later, in_handler=1 until eret pulse. Second irq during HANDLER is ignored.
- Preload stall_cnt near max (force 2^CNT_W−2) and hold stall 3 cycles → reads all-ones; then reset=0 mid-HANDLER → state IDLE, stall_cnt=0, in_handler=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and payload types for the pipeline hazard / interrupt sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned PCSRC_W    = 3;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_SEQ = 3'd0,
        PCSRC_BR  = 3'd1,
        PCSRC_J   = 3'd2,
        PCSRC_JR  = 3'd3
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_TAKE    = 2'd2,
        ST_HANDLER = 2'd3
    } irq_state_e;

    // Per-cycle pipeline steering controls
    typedef struct packed {
        logic pc_wr;
        logic ifid_wr;
        logic ifid_flush;
        logic idex_flush;
        logic exc_pc_sel;
        logic epc_wr;
    } pipe_ctl_t;

    localparam pipe_ctl_t PIPE_CTL_DEFAULT = '{
        pc_wr:      1'b1,
        ifid_wr:    1'b1,
        ifid_flush: 1'b0,
        idex_flush: 1'b0,
        exc_pc_sel: 1'b0,
        epc_wr:     1'b0
    };

    function automatic logic is_jump(input logic [PCSRC_W-1:0] pcsrc);
        return (pcsrc == PCSRC_J) || (pcsrc == PCSRC_JR);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decoder/pipeline side bundle of the hazard controller: ID/EX/MEM hazard info in, steering out.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic [PCSRC_W-1:0] id_pcsrc;
    logic [REG_AW-1:0]  id_rs;
    logic [REG_AW-1:0]  id_rt;
    logic               id_uses_rt;
    logic               ex_memrd;
    logic               ex_regwr;
    logic [REG_AW-1:0]  ex_rd;
    logic               mem_memrd;
    logic [REG_AW-1:0]  mem_rd;
    logic               ex_br_taken;
    logic               irq;
    logic               eret;

    logic               pc_wr;
    logic               ifid_wr;
    logic               ifid_flush;
    logic               idex_flush;
    logic               exc_pc_sel;
    logic               epc_wr;
    logic               irq_ack;
    logic               in_handler;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output id_pcsrc, id_rs, id_rt, id_uses_rt, ex_memrd, ex_regwr, ex_rd,
               mem_memrd, mem_rd, ex_br_taken, irq, eret,
        input  pc_wr, ifid_wr, ifid_flush, idex_flush, exc_pc_sel, epc_wr,
               irq_ack, in_handler, stall_cnt
    );

    modport slave (
        input  id_pcsrc, id_rs, id_rt, id_uses_rt, ex_memrd, ex_regwr, ex_rd,
               mem_memrd, mem_rd, ex_br_taken, irq, eret,
        output pc_wr, ifid_wr, ifid_flush, idex_flush, exc_pc_sel, epc_wr,
               irq_ack, in_handler, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_irq_seq_fsm.sv
// Interrupt entry/return sequencer: IDLE -> PEND -> TAKE (1 cycle) -> HANDLER -> IDLE on eret.
module irq_seq_fsm
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic eret,
    input  logic can_take,
    output logic take_c,
    output logic irq_ack,
    output logic in_handler
);

    irq_state_e state_q, state_d;
    logic       irq_ack_q, irq_ack_d;
    logic       in_handler_q, in_handler_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            irq_ack_q    <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_ack_q    <= irq_ack_d;
            in_handler_q <= in_handler_d;
        end
    end

    // PEND holds the request even if irq drops; HANDLER ignores irq (no nesting)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (irq)      state_d = ST_PEND;
            ST_PEND:    if (can_take) state_d = ST_TAKE;
            ST_TAKE:                  state_d = ST_HANDLER;
            ST_HANDLER: if (eret)     state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
        irq_ack_d    = (state_q == ST_TAKE);
        in_handler_d = (state_d == ST_HANDLER);
    end

    assign take_c     = (state_q == ST_TAKE);
    assign irq_ack    = irq_ack_q;
    assign in_handler = in_handler_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use / jr stalls, branch and jump flushes,
// interrupt entry steering and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
)(
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    logic             load_use_c;
    logic             jr_haz_c;
    logic             stall_raw_c;
    logic             stall_c;
    logic             can_take_c;
    logic             take_c;
    pipe_ctl_t        ctl_c;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Register 0 is hardwired, so it never creates a dependency
    always_comb begin
        load_use_c = bus.ex_memrd && (bus.ex_rd != REG_AW'(0)) &&
                     ((bus.ex_rd == bus.id_rs) ||
                      (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
        jr_haz_c   = (bus.id_pcsrc == PCSRC_JR) && (bus.id_rs != REG_AW'(0)) &&
                     ((bus.ex_regwr && (bus.ex_rd == bus.id_rs)) ||
                      (bus.mem_memrd && (bus.mem_rd == bus.id_rs)));
        stall_raw_c = load_use_c || jr_haz_c;
        // A taken branch or interrupt entry flushes ID anyway, so neither counts as a stall
        stall_c     = stall_raw_c && !bus.ex_br_taken && !take_c;
        can_take_c  = !stall_raw_c && !bus.ex_br_taken && (bus.id_pcsrc == PCSRC_SEQ);
    end

    irq_seq_fsm u_irq_seq (
        .clk        (clk),
        .reset      (reset),
        .irq        (bus.irq),
        .eret       (bus.eret),
        .can_take   (can_take_c),
        .take_c     (take_c),
        .irq_ack    (bus.irq_ack),
        .in_handler (bus.in_handler)
    );

    // Priority: interrupt entry, taken branch, stall, jump
    always_comb begin
        ctl_c = PIPE_CTL_DEFAULT;
        if (bus.ex_br_taken) begin
            ctl_c.ifid_flush = 1'b1;
            ctl_c.idex_flush = 1'b1;
        end else if (stall_raw_c) begin
            ctl_c.pc_wr      = 1'b0;
            ctl_c.ifid_wr    = 1'b0;
            ctl_c.idex_flush = 1'b1;
        end else if (is_jump(bus.id_pcsrc)) begin
            ctl_c.ifid_flush = 1'b1;
        end
        if (take_c) begin
            ctl_c.pc_wr      = 1'b1;
            ctl_c.ifid_wr    = 1'b1;
            ctl_c.ifid_flush = 1'b1;
            ctl_c.idex_flush = 1'b1;
            ctl_c.exc_pc_sel = 1'b1;
            ctl_c.epc_wr     = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_wr      = ctl_c.pc_wr;
    assign bus.ifid_wr    = ctl_c.ifid_wr;
    assign bus.ifid_flush = ctl_c.ifid_flush;
    assign bus.idex_flush = ctl_c.idex_flush;
    assign bus.exc_pc_sel = ctl_c.exc_pc_sel;
    assign bus.epc_wr     = ctl_c.epc_wr;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second 3-bit-counter instance covers saturation.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus_if ();
    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(3))  sm_if ();

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(3)) dut_sm (
        .clk   (clk),
        .reset (reset),
        .bus   (sm_if.slave)
    );

    assign sm_if.id_pcsrc    = bus_if.id_pcsrc;
    assign sm_if.id_rs       = bus_if.id_rs;
    assign sm_if.id_rt       = bus_if.id_rt;
    assign sm_if.id_uses_rt  = bus_if.id_uses_rt;
    assign sm_if.ex_memrd    = bus_if.ex_memrd;
    assign sm_if.ex_regwr    = bus_if.ex_regwr;
    assign sm_if.ex_rd       = bus_if.ex_rd;
    assign sm_if.mem_memrd   = bus_if.mem_memrd;
    assign sm_if.mem_rd      = bus_if.mem_rd;
    assign sm_if.ex_br_taken = bus_if.ex_br_taken;
    assign sm_if.irq         = bus_if.irq;
    assign sm_if.eret        = bus_if.eret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.id_pcsrc    = 3'd0;
        bus_if.id_rs       = 5'd1;
        bus_if.id_rt       = 5'd2;
        bus_if.id_uses_rt  = 1'b0;
        bus_if.ex_memrd    = 1'b0;
        bus_if.ex_regwr    = 1'b0;
        bus_if.ex_rd       = 5'd0;
        bus_if.mem_memrd   = 1'b0;
        bus_if.mem_rd      = 5'd0;
        bus_if.ex_br_taken = 1'b0;
        bus_if.irq         = 1'b0;
        bus_if.eret        = 1'b0;
    endtask

    // pc_wr, ifid_wr, ifid_flush, idex_flush in one nibble
    function automatic logic [3:0] hz();
        return {bus_if.pc_wr, bus_if.ifid_wr, bus_if.ifid_flush, bus_if.idex_flush};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst_hz", 32'(hz()), 32'b1100);
        check_eq("rst_exc", 32'({bus_if.exc_pc_sel, bus_if.epc_wr}), 32'd0);
        check_eq("rst_ack", 32'({bus_if.irq_ack, bus_if.in_handler}), 32'd0);
        check_eq("rst_cnt", bus_if.stall_cnt, 32'd0);
        reset = 1'b1;
        tick();

        // load-use on rs
        bus_if.ex_memrd = 1'b1; bus_if.ex_rd = 5'd8; bus_if.id_rs = 5'd8;
        #1;
        check_eq("lu_hz", 32'(hz()), 32'b0001);
        check_eq("lu_cnt0", bus_if.stall_cnt, 32'd0);
        tick();
        idle_inputs();
        #1;
        check_eq("lu_cnt1", bus_if.stall_cnt, 32'd1);
        check_eq("lu_after_hz", 32'(hz()), 32'b1100);

        // rt match ignored when rt unused, taken when used; r0 never a hazard
        bus_if.ex_memrd = 1'b1; bus_if.ex_rd = 5'd9; bus_if.id_rt = 5'd9;
        #1;
        check_eq("rt_unused", 32'(hz()), 32'b1100);
        bus_if.id_uses_rt = 1'b1;
        #1;
        check_eq("rt_used", 32'(hz()), 32'b0001);
        bus_if.id_uses_rt = 1'b0; bus_if.ex_rd = 5'd0; bus_if.id_rs = 5'd0;
        #1;
        check_eq("r0_nohaz", 32'(hz()), 32'b1100);
        idle_inputs();
        tick();

        // jr after EX load then MEM load: two stalls, then jump flush
        bus_if.id_pcsrc = 3'd3; bus_if.id_rs = 5'd31;
        bus_if.ex_memrd = 1'b1; bus_if.ex_regwr = 1'b1; bus_if.ex_rd = 5'd31;
        #1;
        check_eq("jr_st1", 32'(hz()), 32'b0001);
        tick();
        bus_if.ex_memrd = 1'b0; bus_if.ex_regwr = 1'b0; bus_if.ex_rd = 5'd0;
        bus_if.mem_memrd = 1'b1; bus_if.mem_rd = 5'd31;
        #1;
        check_eq("jr_st2", 32'(hz()), 32'b0001);
        tick();
        bus_if.mem_memrd = 1'b0; bus_if.mem_rd = 5'd0;
        #1;
        check_eq("jr_go", 32'(hz()), 32'b1110);
        check_eq("jr_cnt", bus_if.stall_cnt, 32'd3);
        idle_inputs();
        tick();

        // taken branch beats load-use
        bus_if.ex_br_taken = 1'b1; bus_if.ex_memrd = 1'b1; bus_if.ex_rd = 5'd5; bus_if.id_rs = 5'd5;
        #1;
        check_eq("br_hz", 32'(hz()), 32'b1111);
        tick();
        idle_inputs();
        #1;
        check_eq("br_cnt", bus_if.stall_cnt, 32'd3);

        // interrupt held in PEND across a jump, taken on a sequential slot
        bus_if.irq = 1'b1; bus_if.id_pcsrc = 3'd2;
        #1;
        check_eq("irq_jmp_hz", 32'(hz()), 32'b1110);
        check_eq("irq_idle_exc", 32'(bus_if.exc_pc_sel), 32'd0);
        tick();
        bus_if.irq = 1'b0;
        #1;
        check_eq("pend_jmp_exc", 32'(bus_if.exc_pc_sel), 32'd0);
        tick();
        bus_if.id_pcsrc = 3'd0;
        #1;
        check_eq("pend_seq_exc", 32'(bus_if.exc_pc_sel), 32'd0);
        tick();
        #1;
        check_eq("take_exc", 32'({bus_if.exc_pc_sel, bus_if.epc_wr}), 32'b11);
        check_eq("take_hz", 32'(hz()), 32'b1111);
        check_eq("take_ack", 32'({bus_if.irq_ack, bus_if.in_handler}), 32'b00);
        tick();
        bus_if.irq = 1'b1;
        #1;
        check_eq("hnd_ack", 32'({bus_if.irq_ack, bus_if.in_handler}), 32'b11);
        check_eq("hnd_exc", 32'(bus_if.exc_pc_sel), 32'd0);
        tick();
        bus_if.irq = 1'b0;
        #1;
        check_eq("hnd_ack2", 32'({bus_if.irq_ack, bus_if.in_handler}), 32'b01);
        bus_if.ex_memrd = 1'b1; bus_if.ex_rd = 5'd4; bus_if.id_rs = 5'd4;
        #1;
        check_eq("hnd_stall", 32'(hz()), 32'b0001);
        idle_inputs();
        tick();
        check_eq("hnd_hold", 32'(bus_if.in_handler), 32'd1);
        bus_if.eret = 1'b1;
        #1;
        check_eq("eret_cyc", 32'(bus_if.in_handler), 32'd1);
        tick();
        bus_if.eret = 1'b0;
        #1;
        check_eq("eret_done", 32'(bus_if.in_handler), 32'd0);
        tick();
        check_eq("no_nest1", 32'(bus_if.exc_pc_sel), 32'd0);
        tick();
        check_eq("no_nest2", 32'({bus_if.exc_pc_sel, bus_if.in_handler}), 32'd0);

        // counter saturation on the 3-bit instance
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("sat_rst", 32'(sm_if.stall_cnt), 32'd0);
        bus_if.ex_memrd = 1'b1; bus_if.ex_rd = 5'd7; bus_if.id_rs = 5'd7;
        for (int i = 0; i < 6; i++) tick();
        check_eq("sat_6", 32'(sm_if.stall_cnt), 32'd6);
        for (int i = 0; i < 3; i++) tick();
        check_eq("sat_max", 32'(sm_if.stall_cnt), 32'd7);
        check_eq("big_9", bus_if.stall_cnt, 32'd9);
        idle_inputs();

        // reset while in HANDLER
        bus_if.irq = 1'b1;
        tick();
        bus_if.irq = 1'b0;
        tick();
        check_eq("r_take", 32'(bus_if.exc_pc_sel), 32'd1);
        tick();
        check_eq("r_hnd", 32'(bus_if.in_handler), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("r_inh", 32'({bus_if.irq_ack, bus_if.in_handler}), 32'd0);
        check_eq("r_cnt", bus_if.stall_cnt, 32'd0);
        check_eq("r_cnt_sm", 32'(sm_if.stall_cnt), 32'd0);
        tick();
        check_eq("r_idle", 32'({bus_if.exc_pc_sel, bus_if.in_handler}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
